pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 18 +
 rtl/pipeline_controller_sat_counter.sv | 27 ++
 rtl/pipeline_controller.sv | 113 +++++++++++
 tb/tb_pipeline_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// default parameter values and a width helper for the wait counter.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int CNT_W_DEFAULT   = 16;

   // Bits needed to hold the values 0..timeout inclusive.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Count up on inc, stick at all-ones, clear on request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller. Combines memory stalls, taken branches
// and data hazards into per-stage hold/bubble/flush controls, watches for
// memory accesses that never complete, and keeps two performance counters.
module pipeline_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_counters,
   output logic             freeze_if,
   output logic             bubble_ex,
   output logic             flush_if_id,
   output logic             freeze_back,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int              WC_W     = wait_cnt_width(TIMEOUT);
   localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(TIMEOUT);
   localparam logic [WC_W-1:0] WC_LAST  = WC_LIMIT - WC_W'(1);

   state_t          state;
   logic [WC_W-1:0] wait_cnt;
   logic            mem_stall;

   // Memory stall: an access is outstanding and does not complete this cycle.
   // A completion in MEM_WAIT releases the pipeline in that same cycle.
   always_comb begin
      mem_stall = !mem_ready && ((state == MEM_WAIT) || mem_req);
   end

   // Priority decode of control outputs: memory stall, then branch, then hazard.
   always_comb begin
      freeze_if   = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      freeze_back = 1'b0;
      if (rst_n) begin
         if (mem_stall) begin
            freeze_if   = 1'b1;
            freeze_back = 1'b1;
         end else if (branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
         end else if (hazard) begin
            freeze_if   = 1'b1;
            bubble_ex   = 1'b1;
         end
      end
   end

   // Memory FSM with wait-cycle counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               // Counter parks at the limit; the flag is already set by then.
               if (wait_cnt != WC_LIMIT) begin
                  wait_cnt <= wait_cnt + WC_W'(1);
               end
               if (wait_cnt >= WC_LAST) begin
                  mem_timeout <= 1'b1;
               end
               if (mem_ready) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (freeze_if),
      .clr   (clr_counters),
      .count (stall_cycles)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_if_id),
      .clr   (clr_counters),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_controller.sv
// Testbench for pipeline_controller: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pipeline_controller;

   localparam int TO   = 8;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hazard = 1'b0;
   logic          branch_taken = 1'b0;
   logic          mem_req = 1'b0;
   logic          mem_ready = 1'b0;
   logic          clr_counters = 1'b0;
   logic          freeze_if;
   logic          bubble_ex;
   logic          flush_if_id;
   logic          freeze_back;
   logic          mem_timeout;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] flush_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Behavioural model state
   bit m_wait;
   bit m_to;
   int m_wc;
   int m_stall;
   int m_flush;
   logic [3:0] exp_now;   // {freeze_if, bubble_ex, flush_if_id, freeze_back}

   always #5 clk = ~clk;

   pipeline_controller #(
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hazard       (hazard),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .clr_counters (clr_counters),
      .freeze_if    (freeze_if),
      .bubble_ex    (bubble_ex),
      .flush_if_id  (flush_if_id),
      .freeze_back  (freeze_back),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   function automatic logic [3:0] exp_ctrl(input logic in_wait, input logic h, input logic b,
                                           input logic req, input logic rdy);
      logic [3:0] r;
      r = 4'b0000;
      if (!rdy && (in_wait || req)) r = 4'b1001;
      else if (b)                   r = 4'b0110;
      else if (h)                   r = 4'b1100;
      return r;
   endfunction

   assign exp_now = rst_n ? exp_ctrl(m_wait, hazard, branch_taken, mem_req, mem_ready) : 4'b0000;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: memory wait tracking, sticky timeout, saturating counters
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait  <= 1'b0;
         m_wc    <= 0;
         m_to    <= 1'b0;
         m_stall <= 0;
         m_flush <= 0;
      end else begin
         if (clr_counters) m_stall <= 0;
         else if (exp_now[3] && m_stall < MAXC) m_stall <= m_stall + 1;
         if (clr_counters) m_flush <= 0;
         else if (exp_now[1] && m_flush < MAXC) m_flush <= m_flush + 1;
         if (m_wait) begin
            m_wc <= m_wc + 1;
            if (m_wc + 1 >= TO) m_to <= 1'b1;
            if (mem_ready) m_wait <= 1'b0;
         end else if (mem_req && !mem_ready) begin
            m_wait <= 1'b1;
            m_wc   <= 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_freeze_if",    int'(freeze_if),    int'(exp_now[3]));
         chk("m_bubble_ex",    int'(bubble_ex),    int'(exp_now[2]));
         chk("m_flush_if_id",  int'(flush_if_id),  int'(exp_now[1]));
         chk("m_freeze_back",  int'(freeze_back),  int'(exp_now[0]));
         chk("m_mem_timeout",  int'(mem_timeout),  int'(m_to));
         chk("m_stall_cycles", int'(stall_cycles), m_stall);
         chk("m_flush_count",  int'(flush_count),  m_flush);
      end
   end

   task automatic drive(input bit h, input bit b, input bit req, input bit rdy, input bit clr);
      hazard       = h;
      branch_taken = b;
      mem_req      = req;
      mem_ready    = rdy;
      clr_counters = clr;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with all event inputs active: outputs must stay quiet
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      drive(1, 1, 1, 0, 0);
      chk("rst_freeze_if",    int'(freeze_if),    0);
      chk("rst_bubble_ex",    int'(bubble_ex),    0);
      chk("rst_flush_if_id",  int'(flush_if_id),  0);
      chk("rst_freeze_back",  int'(freeze_back),  0);
      chk("rst_stall_cycles", int'(stall_cycles), 0);
      chk("rst_flush_count",  int'(flush_count),  0);
      chk("rst_mem_timeout",  int'(mem_timeout),  0);
      drive(0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;

      // Hazard for three cycles
      drive(0, 0, 0, 0, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0);
         chk("haz_freeze_if", int'(freeze_if), 1);
         chk("haz_bubble_ex", int'(bubble_ex), 1);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      chk("haz_end_freeze_if", int'(freeze_if), 0);
      chk("haz_stall_cycles",  int'(stall_cycles), 3);
      tick();

      // Branch and hazard together
      drive(0, 0, 0, 0, 1);
      tick();
      drive(1, 1, 0, 0, 0);
      chk("br_flush_if_id", int'(flush_if_id), 1);
      chk("br_bubble_ex",   int'(bubble_ex),   1);
      chk("br_freeze_if",   int'(freeze_if),   0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("br_flush_count",  int'(flush_count),  1);
      chk("br_stall_cycles", int'(stall_cycles), 0);
      tick();

      // Four-cycle memory wait
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0, 0);
         chk("mw_freeze_back", int'(freeze_back), 1);
         tick();
      end
      drive(0, 0, 1, 1, 0);
      chk("mw_done_freeze_back", int'(freeze_back), 0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("mw_back_in_run", int'(freeze_back), 0);
      chk("mw_no_timeout",  int'(mem_timeout), 0);
      tick();

      // Memory never ready for 20 cycles: timeout after 8 wait cycles
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 1, 0, 0);
         chk("to_mem_timeout", int'(mem_timeout), (i >= 9) ? 1 : 0);
         tick();
      end
      drive(0, 0, 1, 1, 0);
      chk("to_ready_freeze_back", int'(freeze_back), 0);
      chk("to_sticky_a",          int'(mem_timeout), 1);
      chk("sat_stall_cycles",     int'(stall_cycles), 15);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("to_sticky_b", int'(mem_timeout), 1);
      tick();

      // Clear wins over increment
      drive(1, 0, 0, 0, 1);
      chk("clr_freeze_if", int'(freeze_if), 1);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("clr_stall_cycles", int'(stall_cycles), 0);
      tick();

      // Reset in the middle of a memory wait
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 0);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_freeze_back",  int'(freeze_back),  0);
      chk("arst_freeze_if",    int'(freeze_if),    0);
      chk("arst_mem_timeout",  int'(mem_timeout),  0);
      chk("arst_stall_cycles", int'(stall_cycles), 0);
      chk("arst_flush_count",  int'(flush_count),  0);
      tick();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0);
      chk("arst_resume_run", int'(freeze_back), 0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 29) == 0));
         tick();
      end

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
